// File: rtl/exe_muldiv_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// FSM states and default datapath widths.
package exe_muldiv_seq_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/exe_muldiv_seq_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial subtract
// for divide. Purely combinational; the sequencer owns all state.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_mq,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_mq
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_unused_diff;

    assign w_sum   = {1'b0, i_acc} + (i_mq[0] ? {1'b0, i_m} : '0);
    assign w_shift = {i_acc, i_mq[WIDTH-1]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, i_m};

    // A successful trial leaves a remainder below the divisor, so bit WIDTH is always 0
    assign w_unused_diff = w_diff[WIDTH];

    always_comb begin
        o_acc = i_acc;
        o_mq  = i_mq;
        if (i_is_div) begin
            if (w_diff[WIDTH+1]) begin
                o_acc = w_shift[WIDTH-1:0];
                o_mq  = {i_mq[WIDTH-2:0], 1'b0};
            end else begin
                o_acc = w_diff[WIDTH-1:0];
                o_mq  = {i_mq[WIDTH-2:0], 1'b1};
            end
        end else begin
            o_acc = w_sum[WIDTH:1];
            o_mq  = {w_sum[0], i_mq[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/exe_muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Operates on magnitudes for WIDTH iterations, then applies sign fixup.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no op in flight; MTHI/MTLO honoured; start accepted
// ST_RUN  | one radix-2 iteration per cycle, counter 0..WIDTH-1
// ST_FIX  | sign correction, HI/LO written, done pulsed next cycle
module exe_muldiv_seq
    import exe_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mq;
    logic [WIDTH-1:0]   r_m;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_signed;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_mq_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_accept = (r_state == ST_IDLE) && start && !flush;
    assign w_signed = op_is_signed(op);
    assign w_a_mag  = (w_signed && src1[WIDTH-1]) ? -src1 : src1;
    assign w_b_mag  = (w_signed && src2[WIDTH-1]) ? -src2 : src2;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_mq     (r_mq),
        .i_m      (r_m),
        .o_acc    (w_acc_nxt),
        .o_mq     (w_mq_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start && !flush) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (flush)                  w_state_nxt = ST_IDLE;
                else if (r_cnt == CNT_LAST) w_state_nxt = ST_FIX;
            end
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign w_prod     = {r_acc, r_mq};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

    // Divide-by-zero leaves quotient all ones and remainder |src1|; restoring
    // the dividend sign on the remainder gives back the raw src1.
    always_comb begin
        w_res_hi = r_acc;
        w_res_lo = r_mq;
        if (!r_is_div) begin
            w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod_fix[WIDTH-1:0];
        end else if (r_dz) begin
            w_res_hi = r_neg_r ? -r_acc : r_acc;
            w_res_lo = '1;
        end else begin
            w_res_hi = r_neg_r ? -r_acc : r_acc;
            w_res_lo = r_neg_q ? -r_mq : r_mq;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mq     <= '0;
            r_m      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy && hi_we) r_hi <= wdata;
            if (!r_busy && lo_we) r_lo <= wdata;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_mq     <= w_a_mag;
                        r_m      <= w_b_mag;
                        r_is_div <= op_is_div(op);
                        r_neg_q  <= w_signed && (src1[WIDTH-1] ^ src2[WIDTH-1]);
                        r_neg_r  <= w_signed && src1[WIDTH-1];
                        r_dz     <= (src2 == '0);
                    end
                end
                ST_RUN: begin
                    if (!flush) begin
                        r_acc <= w_acc_nxt;
                        r_mq  <= w_mq_nxt;
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_FIX: begin
                    if (!flush) begin
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_exe_muldiv_seq.sv
// Scoreboard bench for exe_muldiv_seq: issued ops push model results,
// a negedge monitor pops and compares whenever done pulses.
module tb_exe_muldiv_seq;

    localparam int W   = 32;
    localparam int LAT = 34;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  src1;
    logic [W-1:0]  src2;
    logic          flush;
    logic          hi_we;
    logic          lo_we;
    logic [W-1:0]  wdata;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    exe_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .flush  (flush),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: architectural results from plain integer arithmetic
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      la;
        longint      lb;
        int          ia;
        int          ib;
        e.due = 0;
        e.hi  = '0;
        e.lo  = '0;
        case (o)
            2'b00: begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
                p  = 64'(la * lb);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b10: begin
                if (b == 0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = 32'h0;
                end else begin
                    ia = $signed(a);
                    ib = $signed(b);
                    e.lo = 32'(ia / ib);
                    e.hi = 32'(ia % ib);
                end
            end
            default: begin
                if (b == 0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (resetn === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                mon_e = sb.pop_front();
                check("hi", hi, mon_e.hi);
                check("lo", lo, mon_e.lo);
                check("done_cycle", 32'(cyc), 32'(mon_e.due));
                check("busy_at_done", {31'b0, busy}, 32'd0);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns one negedge later
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
        exp_t e;
        e = model(o, a, b);
        e.due = cyc + LAT;
        start = 1'b1;
        op    = o;
        src1  = a;
        src2  = b;
        if (track) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        src1  = $urandom;
        src2  = $urandom;
        check("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        int k = 0;
        while (done !== 1'b1 && k < LAT + 10) begin
            @(negedge clk);
            k++;
        end
        if (done !== 1'b1) fail_now("wait_done_timeout");
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < LAT + 10) begin
            @(negedge clk);
            k++;
        end
        if (busy !== 1'b0) fail_now("wait_idle_timeout");
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            4:       return 32'($urandom_range(0, 20));
            5:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        src1   = '0;
        src2   = '0;
        flush  = 1'b0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        wdata  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed ops, each issued in the done cycle of the previous one
        issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1);          wait_done();
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);  wait_done();
        issue(2'b11, 32'd100, 32'd7, 1);                wait_done();
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1);          wait_done();
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1);  wait_done();
        issue(2'b10, 32'd5, 32'd0, 1);                  wait_done();
        issue(2'b10, 32'hFFFF_FFFB, 32'd0, 1);          wait_done();
        issue(2'b11, 32'h8000_0000, 32'd0, 1);          wait_done();

        // MTHI/MTLO while busy must be ignored
        issue(2'b11, 32'd1000, 32'd3, 1);
        repeat (5) @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hAA;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        wait_done();

        // MTHI together with an accepted start: write lands, op overwrites later
        hi_we = 1'b1;
        wdata = 32'h5A5A;
        issue(2'b01, 32'd3, 32'd4, 1);
        hi_we = 1'b0;
        check("mthi_with_start", hi, 32'h5A5A);
        wait_done();

        // Flush mid-op
        @(negedge clk);
        wait_idle();
        hi_we = 1'b1;
        wdata = 32'h11;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = 32'h22;
        @(negedge clk);
        lo_we = 1'b0;
        issue(2'b11, $urandom, 32'd9, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_drop", {31'b0, busy}, 32'd0);
        check("flush_hi", hi, 32'h11);
        check("flush_lo", lo, 32'h22);
        start = 1'b1;
        flush = 1'b1;
        op    = 2'b00;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_with_start", {31'b0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        check("flush_hi_late", hi, 32'h11);
        check("flush_lo_late", lo, 32'h22);
        issue(2'b00, 32'hFFFF_FF00, 32'h0000_0123, 1);
        wait_done();

        // Randomized ops, mixing back-to-back issue and idle gaps
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            issue(2'($urandom_range(0, 3)), pick(), pick(), 1);
            wait_done();
        end

        // Asynchronous reset mid-RUN
        @(negedge clk);
        wait_idle();
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        issue(2'b01, 32'hFFFF_FFFF, 32'd2, 0);
        repeat (12) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("amid_rst_busy", {31'b0, busy}, 32'd0);
        check("amid_rst_hi", hi, 32'h0);
        check("amid_rst_lo", lo, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_busy", {31'b0, busy}, 32'd0);
        issue(2'b10, 32'hFFFF_FF9C, 32'd7, 1);
        wait_done();
        @(negedge clk);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
